dcache_sram_nway: RTL and testbench

Parametrised N-way set-associative data-cache storage array with true-LRU replacement, the successor of the fixed 2-way/16-set cache SRAM. It sits under the data-cache controller and holds tag, valid, dirty and line data per way. It reports hit and hit-way contents combinationally. On a miss it presents the selected victim line so the controller can write it back before the fill. Writes and LRU updates are synchronous.

---
 rtl/dcache_sram_nway.sv | 122 ++++++++++++
 tb/tb_dcache_sram_nway.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dcache_sram_nway.sv
// N-way set-associative data-cache storage: tag/valid/dirty/line per way with true-LRU ages.
// Lookup and victim selection are combinational; writes and age updates happen on the clock edge.
module dcache_sram_nway #(
  parameter  int NUM_SETS = 16,
  parameter  int WAYS     = 2,
  parameter  int TAG_W    = 23,
  parameter  int LINE_W   = 256,
  localparam int IDX_W    = $clog2(NUM_SETS),
  localparam int AGE_W    = $clog2(WAYS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [TAG_W+1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              hit_o,
  output logic [AGE_W-1:0]  hit_way_o,
  output logic [AGE_W-1:0]  victim_way_o,
  output logic [TAG_W+1:0]  tag_o,
  output logic [LINE_W-1:0] data_o
);

  logic [TAG_W+1:0]  tag_q  [NUM_SETS][WAYS];
  logic [TAG_W+1:0]  tag_d  [NUM_SETS][WAYS];
  logic [LINE_W-1:0] data_q [NUM_SETS][WAYS];
  logic [LINE_W-1:0] data_d [NUM_SETS][WAYS];
  logic [AGE_W-1:0]  age_q  [NUM_SETS][WAYS];
  logic [AGE_W-1:0]  age_d  [NUM_SETS][WAYS];

  logic              hit_s;
  logic [AGE_W-1:0]  hit_way_s;
  logic              inv_found_s;
  logic [AGE_W-1:0]  inv_way_s;
  logic [AGE_W-1:0]  lru_way_s;
  logic [AGE_W-1:0]  victim_s;
  logic [AGE_W-1:0]  sel_way_s;
  logic [AGE_W-1:0]  old_age_s;

  // Hit detection (lowest matching way wins) and victim selection for the addressed set
  always_comb begin
    hit_s       = 1'b0;
    hit_way_s   = {AGE_W{1'b0}};
    inv_found_s = 1'b0;
    inv_way_s   = {AGE_W{1'b0}};
    lru_way_s   = {AGE_W{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_s && tag_q[addr_i][w][TAG_W+1] &&
          (tag_q[addr_i][w][TAG_W-1:0] == tag_i[TAG_W-1:0])) begin
        hit_s     = 1'b1;
        hit_way_s = AGE_W'(w);
      end else begin
        hit_s     = hit_s;
      end
      if (!inv_found_s && !tag_q[addr_i][w][TAG_W+1]) begin
        inv_found_s = 1'b1;
        inv_way_s   = AGE_W'(w);
      end else begin
        inv_found_s = inv_found_s;
      end
      if (age_q[addr_i][w] == AGE_W'(WAYS-1)) begin
        lru_way_s = AGE_W'(w);
      end else begin
        lru_way_s = lru_way_s;
      end
    end
    victim_s  = inv_found_s ? inv_way_s : lru_way_s;
    sel_way_s = hit_s ? hit_way_s : victim_s;
    old_age_s = age_q[addr_i][sel_way_s];
  end

  assign hit_o        = hit_s;
  assign hit_way_o    = hit_way_s;
  assign victim_way_o = victim_s;
  assign tag_o        = tag_q[addr_i][sel_way_s];
  assign data_o       = data_q[addr_i][sel_way_s];

  // Next-state: write/fill into the selected way, then touch it (MRU, younger ways age by one)
  always_comb begin
    tag_d  = tag_q;
    data_d = data_q;
    age_d  = age_q;
    if (enable_i && write_i) begin
      tag_d[addr_i][sel_way_s]  = tag_i;
      data_d[addr_i][sel_way_s] = data_i;
    end else begin
      tag_d = tag_d;
    end
    if (enable_i && (write_i || hit_s)) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == sel_way_s) begin
          age_d[addr_i][w] = {AGE_W{1'b0}};
        end else if (age_q[addr_i][w] < old_age_s) begin
          age_d[addr_i][w] = age_q[addr_i][w] + AGE_W'(1);
        end else begin
          age_d[addr_i][w] = age_q[addr_i][w];
        end
      end
    end else begin
      age_d = age_d;
    end
  end

  // State registers; reset clears contents and makes way 0 the LRU of every set
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]  <= '0;
          data_q[s][w] <= '0;
          age_q[s][w]  <= AGE_W'(WAYS-1-w);
        end
      end
    end else begin
      tag_q  <= tag_d;
      data_q <= data_d;
      age_q  <= age_d;
    end
  end

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Directed self-checking bench for dcache_sram_nway: a 2-way and a 4-way instance.
module tb_dcache_sram_nway;
  localparam int TAG_W  = 23;
  localparam int LINE_W = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 2-way instance
  logic [3:0]        addr;
  logic [TAG_W+1:0]  tag;
  logic [LINE_W-1:0] data;
  logic              en, wr;
  logic              hit;
  logic [0:0]        hit_way, victim;
  logic [TAG_W+1:0]  tag_out;
  logic [LINE_W-1:0] data_out;

  // 4-way instance
  logic [3:0]        addr4;
  logic [TAG_W+1:0]  tag4;
  logic [LINE_W-1:0] data4;
  logic              en4, wr4;
  logic              hit4;
  logic [1:0]        hit_way4, victim4;
  logic [TAG_W+1:0]  tag_out4;
  logic [LINE_W-1:0] data_out4;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [LINE_W-1:0] DA = {8{32'hAAAA_0001}};
  localparam logic [LINE_W-1:0] DB = {8{32'hBBBB_0002}};
  localparam logic [LINE_W-1:0] DC = {8{32'hCCCC_0003}};
  localparam logic [LINE_W-1:0] DD = {8{32'hDDDD_0004}};
  localparam logic [LINE_W-1:0] DE = {8{32'hEEEE_0005}};

  dcache_sram_nway #(.NUM_SETS(16), .WAYS(2), .TAG_W(TAG_W), .LINE_W(LINE_W)) u_dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .tag_i(tag), .data_i(data),
    .enable_i(en), .write_i(wr), .hit_o(hit), .hit_way_o(hit_way),
    .victim_way_o(victim), .tag_o(tag_out), .data_o(data_out));

  dcache_sram_nway #(.NUM_SETS(16), .WAYS(4), .TAG_W(TAG_W), .LINE_W(LINE_W)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr4), .tag_i(tag4), .data_i(data4),
    .enable_i(en4), .write_i(wr4), .hit_o(hit4), .hit_way_o(hit_way4),
    .victim_way_o(victim4), .tag_o(tag_out4), .data_o(data_out4));

  function automatic logic [TAG_W+1:0] tw(input logic v, input logic d, input logic [TAG_W-1:0] t);
    return {v, d, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic w, input logic [3:0] a,
                       input logic [TAG_W+1:0] t, input logic [LINE_W-1:0] d);
    en = e; wr = w; addr = a; tag = t; data = d;
    #1;
  endtask

  task automatic drive4(input logic e, input logic w, input logic [3:0] a,
                        input logic [TAG_W+1:0] t, input logic [LINE_W-1:0] d);
    en4 = e; wr4 = w; addr4 = a; tag4 = t; data4 = d;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'd0, '0, '0);
    drive4(1'b0, 1'b0, 4'd0, '0, '0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'd3, tw(1'b0, 1'b0, 23'h12), '0);
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %0b want 0", hit); end
    n_checks++; if (hit_way !== 1'b0) begin n_fail++; $display("FAIL reset_hit_way got %0d want 0", hit_way); end
    n_checks++; if (victim !== 1'b0) begin n_fail++; $display("FAIL reset_victim got %0d want 0", victim); end
    n_checks++; if (tag_out !== '0) begin n_fail++; $display("FAIL reset_tag got %h want 0", tag_out); end
    n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", data_out); end
  endtask

  task automatic test_fill();
    drive(1'b1, 1'b1, 4'd3, tw(1'b1, 1'b0, 23'h12), DA);
    n_checks++; if (victim !== 1'b0) begin n_fail++; $display("FAIL fill1_victim got %0d want 0", victim); end
    tick();
    drive(1'b1, 1'b1, 4'd3, tw(1'b1, 1'b0, 23'h34), DB);
    n_checks++; if (victim !== 1'b1) begin n_fail++; $display("FAIL fill2_victim got %0d want 1", victim); end
    tick();
    drive(1'b0, 1'b0, 4'd3, tw(1'b0, 1'b0, 23'h12), '0);
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL fill_hit12 got %0b want 1", hit); end
    n_checks++; if (hit_way !== 1'b0) begin n_fail++; $display("FAIL fill_way12 got %0d want 0", hit_way); end
    n_checks++; if (data_out !== DA) begin n_fail++; $display("FAIL fill_data12 got %h want %h", data_out, DA); end
    drive(1'b0, 1'b0, 4'd3, tw(1'b0, 1'b0, 23'h34), '0);
    n_checks++; if (hit_way !== 1'b1 || hit !== 1'b1) begin n_fail++; $display("FAIL fill_hit34 got hit %0b way %0d want 1/1", hit, hit_way); end
    n_checks++; if (data_out !== DB) begin n_fail++; $display("FAIL fill_data34 got %h want %h", data_out, DB); end
  endtask

  task automatic test_lru_replace();
    drive(1'b1, 1'b0, 4'd3, tw(1'b0, 1'b0, 23'h12), '0);
    tick();
    drive(1'b1, 1'b1, 4'd3, tw(1'b1, 1'b0, 23'h56), DD);
    n_checks++; if (hit !== 1'b0 || victim !== 1'b1) begin n_fail++; $display("FAIL lru_victim got hit %0b victim %0d want 0/1", hit, victim); end
    tick();
    drive(1'b0, 1'b0, 4'd3, tw(1'b0, 1'b0, 23'h34), '0);
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL lru_miss34 got %0b want 0", hit); end
    n_checks++; if (victim !== 1'b0) begin n_fail++; $display("FAIL lru_victim2 got %0d want 0", victim); end
    n_checks++; if (tag_out !== tw(1'b1, 1'b0, 23'h12)) begin n_fail++; $display("FAIL lru_tag got %h want %h", tag_out, tw(1'b1, 1'b0, 23'h12)); end
    n_checks++; if (data_out !== DA) begin n_fail++; $display("FAIL lru_data got %h want %h", data_out, DA); end
    drive(1'b0, 1'b0, 4'd3, tw(1'b0, 1'b0, 23'h56), '0);
    n_checks++; if (hit !== 1'b1 || hit_way !== 1'b1 || data_out !== DD) begin n_fail++; $display("FAIL lru_hit56 got hit %0b way %0d data %h want 1/1/%h", hit, hit_way, data_out, DD); end
  endtask

  task automatic test_write_hit();
    drive(1'b1, 1'b1, 4'd3, tw(1'b1, 1'b1, 23'h12), DC);
    n_checks++; if (data_out !== DA || hit !== 1'b1) begin n_fail++; $display("FAIL rdw_pre got hit %0b data %h want 1/%h", hit, data_out, DA); end
    tick();
    drive(1'b0, 1'b0, 4'd3, tw(1'b0, 1'b0, 23'h12), '0);
    n_checks++; if (hit !== 1'b1 || hit_way !== 1'b0) begin n_fail++; $display("FAIL wh_hit got hit %0b way %0d want 1/0", hit, hit_way); end
    n_checks++; if (tag_out !== tw(1'b1, 1'b1, 23'h12)) begin n_fail++; $display("FAIL wh_tag got %h want %h", tag_out, tw(1'b1, 1'b1, 23'h12)); end
    n_checks++; if (data_out !== DC) begin n_fail++; $display("FAIL wh_data got %h want %h", data_out, DC); end
    drive(1'b0, 1'b0, 4'd4, tw(1'b0, 1'b0, 23'h12), '0);
    n_checks++; if (hit !== 1'b0 || tag_out !== '0 || data_out !== '0 || victim !== 1'b0) begin n_fail++; $display("FAIL wh_other_set got hit %0b tag %h victim %0d", hit, tag_out, victim); end
  endtask

  task automatic test_read_miss();
    drive(1'b1, 1'b0, 4'd3, tw(1'b0, 1'b0, 23'h99), '0);
    n_checks++; if (victim !== 1'b1) begin n_fail++; $display("FAIL miss_victim_pre got %0d want 1", victim); end
    tick();
    n_checks++; if (victim !== 1'b1 || tag_out !== tw(1'b1, 1'b0, 23'h56) || data_out !== DD) begin n_fail++; $display("FAIL miss_nochange got victim %0d tag %h want 1/%h", victim, tag_out, tw(1'b1, 1'b0, 23'h56)); end
    drive(1'b0, 1'b0, 4'd3, '0, '0);
  endtask

  task automatic test_ways4();
    // Fill ways 0..3, ages become [3,2,1,0]
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, 1'b1, 4'd5, tw(1'b1, 1'b0, 23'(32'h100 + i)), {8{32'(i)}});
      n_checks++; if (victim4 !== 2'(i)) begin n_fail++; $display("FAIL w4_fill%0d_victim got %0d want %0d", i, victim4, i); end
      tick();
    end
    drive4(1'b1, 1'b0, 4'd5, tw(1'b0, 1'b0, 23'h101), '0);
    n_checks++; if (hit4 !== 1'b1 || hit_way4 !== 2'd1) begin n_fail++; $display("FAIL w4_touch1 got hit %0b way %0d want 1/1", hit4, hit_way4); end
    tick();
    drive4(1'b1, 1'b1, 4'd5, tw(1'b1, 1'b0, 23'h200), DE);
    n_checks++; if (victim4 !== 2'd0) begin n_fail++; $display("FAIL w4_replace got %0d want 0", victim4); end
    tick();
    // Ages now [0,1,3,2]: LRU is way 2
    drive4(1'b0, 1'b0, 4'd5, tw(1'b0, 1'b0, 23'h200), '0);
    n_checks++; if (hit4 !== 1'b1 || hit_way4 !== 2'd0 || data_out4 !== DE) begin n_fail++; $display("FAIL w4_newline got hit %0b way %0d", hit4, hit_way4); end
    n_checks++; if (victim4 !== 2'd2) begin n_fail++; $display("FAIL w4_lru_after got %0d want 2", victim4); end
    drive4(1'b1, 1'b0, 4'd5, tw(1'b0, 1'b0, 23'h103), '0);
    tick();
    // Ages [1,2,3,0]
    drive4(1'b0, 1'b0, 4'd5, tw(1'b0, 1'b0, 23'h999), '0);
    n_checks++; if (victim4 !== 2'd2) begin n_fail++; $display("FAIL w4_touch3 got %0d want 2", victim4); end
    drive4(1'b1, 1'b0, 4'd5, tw(1'b0, 1'b0, 23'h102), '0);
    tick();
    // Ages [2,3,0,1]
    drive4(1'b0, 1'b0, 4'd5, tw(1'b0, 1'b0, 23'h999), '0);
    n_checks++; if (victim4 !== 2'd1 || tag_out4 !== tw(1'b1, 1'b0, 23'h101)) begin n_fail++; $display("FAIL w4_touch2 got victim %0d tag %h want 1/%h", victim4, tag_out4, tw(1'b1, 1'b0, 23'h101)); end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1;
    drive(1'b1, 1'b1, 4'd3, tw(1'b1, 1'b0, 23'h77), DE);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'd3, tw(1'b0, 1'b0, 23'h77), '0);
    n_checks++; if (hit !== 1'b0 || hit_way !== 1'b0 || victim !== 1'b0 || tag_out !== '0 || data_out !== '0) begin n_fail++; $display("FAIL rstpri_77 got hit %0b way %0d victim %0d tag %h", hit, hit_way, victim, tag_out); end
    drive(1'b0, 1'b0, 4'd3, tw(1'b0, 1'b0, 23'h12), '0);
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL rstpri_12 got %0b want 0", hit); end
    drive4(1'b0, 1'b0, 4'd5, tw(1'b0, 1'b0, 23'h200), '0);
    n_checks++; if (hit4 !== 1'b0 || victim4 !== 2'd0 || data_out4 !== '0) begin n_fail++; $display("FAIL rstpri_w4 got hit %0b victim %0d", hit4, victim4); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_lru_replace();
    test_write_hit();
    test_read_miss();
    test_ways4();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
